// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by the ALU control decoder),
// execution FSM state type and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_DATA_WIDTH = 32;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_NOR     = 4'b0010;
    localparam logic [3:0] ALU_ADD     = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0100;
    localparam logic [3:0] ALU_SLL     = 4'b0101;
    localparam logic [3:0] ALU_SRL     = 4'b0110;
    localparam logic [3:0] ALU_LUI     = 4'b0111;
    localparam logic [3:0] ALU_MULTU   = 4'b1000;
    localparam logic [3:0] ALU_INVALID = 4'b1001;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDone
    } alu_state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// DATA_WIDTH cycles per multiply. o_last flags the final step and
// o_product_next carries the product that step produces.
module shift_add_multiplier #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [DATA_WIDTH-1:0]     i_a,
    input  logic [DATA_WIDTH-1:0]     i_b,
    output logic                      o_last,
    output logic [2*DATA_WIDTH-1:0]   o_product_next
);

    localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                    r_run;
    logic [CW-1:0]           r_count;
    logic [DATA_WIDTH-1:0]   r_mcand;
    // Upper half accumulates, lower half starts as the multiplier and shifts out.
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH:0]     w_sum;
    logic [2*DATA_WIDTH-1:0] w_acc_next;

    // Add multiplicand when the current multiplier bit is set, then shift right.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + {1'b0, (r_acc[0] ? r_mcand : {DATA_WIDTH{1'b0}})};
        w_acc_next = {w_sum, r_acc[DATA_WIDTH-1:1]};
    end

    assign o_last         = r_run && (r_count == CW'(DATA_WIDTH - 1));
    assign o_product_next = w_acc_next;

    // Operand latch on start, one step per cycle while running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run   <= 1'b0;
            r_count <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
        end else if (i_start && !r_run) begin
            r_run   <= 1'b1;
            r_count <= '0;
            r_mcand <= i_a;
            r_acc   <= {{DATA_WIDTH{1'b0}}, i_b};
        end else if (r_run) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CW'(1);
            if (o_last) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution stage: single-cycle logic/arithmetic/shift ops with a
// registered result, plus optional iterative MULTU behind busy/valid.
// Define ALU_MULT_EN to build the multiplier; otherwise MULTU is reported
// as an unsupported op.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            alu_operation_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [4:0]            shamt_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic                  zero_o,
    output logic                  err_o
);

    logic                    r_valid;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [DATA_WIDTH-1:0]   r_hi;

    logic                    w_busy;
    logic                    w_accept;
    logic                    w_accept_mul;
    logic                    w_mul_last;
    logic [2*DATA_WIDTH-1:0] w_product;
    logic [DATA_WIDTH-1:0]   w_res;
    logic                    w_err;

    assign w_accept = start_i && !w_busy;

`ifdef ALU_MULT_EN
    alu_state_e r_state;
    alu_state_e w_state_next;

    assign w_busy       = (r_state != StIdle);
    assign w_accept_mul = w_accept && (alu_operation_i == ALU_MULTU);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: IDLE -> MUL on MULTU accept, MUL -> DONE on final step.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept_mul) w_state_next = StMul;
            StMul:   if (w_mul_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    shift_add_multiplier #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .i_clk          (clk),
        .i_rst_n        (reset),
        .i_start        (w_accept_mul),
        .i_a            (a_i),
        .i_b            (b_i),
        .o_last         (w_mul_last),
        .o_product_next (w_product)
    );
`else
    assign w_busy       = 1'b0;
    assign w_accept_mul = 1'b0;
    assign w_mul_last   = 1'b0;
    assign w_product    = '0;
`endif

    // Single-cycle op decode; anything unrecognised (incl. MULTU here) is an error.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (alu_operation_i)
            ALU_AND: w_res = a_i & b_i;
            ALU_OR:  w_res = a_i | b_i;
            ALU_NOR: w_res = ~(a_i | b_i);
            ALU_ADD: w_res = a_i + b_i;
            ALU_SUB: w_res = a_i - b_i;
            ALU_SLL: w_res = b_i << shamt_i;
            ALU_SRL: w_res = b_i >> shamt_i;
            ALU_LUI: w_res = DATA_WIDTH'(b_i[15:0]) << 16;
            default: w_err = 1'b1;
        endcase
    end

    // Result registers load only on a completion and hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
            r_hi     <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_mul_last) begin
                r_valid  <= 1'b1;
                r_err    <= 1'b0;
                r_result <= w_product[DATA_WIDTH-1:0];
                r_hi     <= w_product[2*DATA_WIDTH-1:DATA_WIDTH];
            end else if (w_accept && !w_accept_mul) begin
                r_valid  <= 1'b1;
                r_err    <= w_err;
                r_result <= w_res;
                r_hi     <= '0;
            end
        end
    end

    assign busy_o   = w_busy;
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign hi_o     = r_hi;
    assign err_o    = r_err;
    assign zero_o   = (r_result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a cycle-level reference model is
// compared against the DUT every cycle, plus literal expectations.
module tb_alu_exec_unit;

    localparam int unsigned W = 32;
`ifdef ALU_MULT_EN
    localparam bit MultEn = 1'b1;
`else
    localparam bit MultEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i = 1'b0;
    logic [3:0]    alu_operation_i = 4'd0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic [4:0]    shamt_i = '0;
    logic          busy_o, valid_o, zero_o, err_o;
    logic [W-1:0]  result_o, hi_o;

    int            n_checks = 0;
    int            n_errors = 0;
    bit            cmp_en = 1'b0;

    // Reference model state
    int            m_cnt;
    logic          m_valid;
    logic          m_err;
    logic [W-1:0]  m_res;
    logic [W-1:0]  m_hi;
    logic [63:0]   m_prod;

    alu_exec_unit #(.DATA_WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .alu_operation_i (alu_operation_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .shamt_i         (shamt_i),
        .busy_o          (busy_o),
        .valid_o         (valid_o),
        .result_o        (result_o),
        .hi_o            (hi_o),
        .zero_o          (zero_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [4:0] sh);
        logic [W-1:0] hw;
        case (op)
            4'd0: return a & b;
            4'd1: return a | b;
            4'd2: return ~(a | b);
            4'd3: return a + b;
            4'd4: return a - b;
            4'd5: return b << sh;
            4'd6: return b >> sh;
            4'd7: begin
                hw = b & 32'h0000_FFFF;
                return hw * 32'd65536;
            end
            default: return '0;
        endcase
    endfunction

    // Model: MULTU keeps the unit busy for W+1 cycles and delivers on the last-but-one.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_res   <= '0;
            m_hi    <= '0;
            m_prod  <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 2) begin
                    m_valid <= 1'b1;
                    m_err   <= 1'b0;
                    m_res   <= m_prod[31:0];
                    m_hi    <= m_prod[63:32];
                end
            end else if (start_i) begin
                if (MultEn && alu_operation_i == 4'b1000) begin
                    m_cnt  <= W + 1;
                    m_prod <= {32'b0, a_i} * {32'b0, b_i};
                end else begin
                    m_valid <= 1'b1;
                    m_err   <= (alu_operation_i > 4'd7);
                    m_res   <= ref_res(alu_operation_i, a_i, b_i, shamt_i);
                    m_hi    <= '0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid_o", 64'(valid_o), 64'(m_valid));
            check("busy_o", 64'(busy_o), 64'(m_cnt != 0));
            check("result_o", 64'(result_o), 64'(m_res));
            check("hi_o", 64'(hi_o), 64'(m_hi));
            check("zero_o", 64'(zero_o), 64'(m_res == '0));
            check("err_o", 64'(err_o), 64'(m_err));
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh);
        @(negedge clk);
        start_i = 1'b1;
        alu_operation_i = op;
        a_i = a;
        b_i = b;
        shamt_i = sh;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    logic [3:0]   v_op [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd5, 4'd7, 4'd15};
    logic [W-1:0] v_a  [9] = '{32'hF0F0_00FF, 32'h1200_0034, 32'h0, 32'h7FFF_FFFF,
                               32'h3, 32'h0, 32'h0, 32'h0, 32'h5};
    logic [W-1:0] v_b  [9] = '{32'h0FF0_F0F0, 32'h0056_0000, 32'h0, 32'h1,
                               32'h5, 32'h8000_0000, 32'hA5, 32'hABCD_1234, 32'h6};
    logic [4:0]   v_sh [9] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd8, 5'd0, 5'd0};

    int k;
    int seen;

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_zero", 64'(zero_o), 64'd1);
        check("rst_result", 64'(result_o), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_valid", 64'(valid_o), 64'd0);

        issue(4'd3, 32'hFFFF_FFFF, 32'h2, 5'd0);
        check("add_wrap_valid", 64'(valid_o), 64'd1);
        check("add_wrap", 64'(result_o), 64'h1);
        check("add_wrap_zero", 64'(zero_o), 64'd0);
        issue(4'd4, 32'd5, 32'd5, 5'd0);
        check("sub_zero_res", 64'(result_o), 64'h0);
        check("sub_zero", 64'(zero_o), 64'd1);
        issue(4'd5, 32'h0, 32'h1, 5'd31);
        check("sll31", 64'(result_o), 64'h8000_0000);
        issue(4'd7, 32'h0, 32'h1234, 5'd0);
        check("lui", 64'(result_o), 64'h1234_0000);
        issue(4'b1001, 32'h7, 32'h9, 5'd0);
        check("inv_err", 64'(err_o), 64'd1);
        check("inv_res", 64'(result_o), 64'h0);

        // Back-to-back starts every cycle.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start_i = 1'b1;
            alu_operation_i = v_op[i];
            a_i = v_a[i];
            b_i = v_b[i];
            shamt_i = v_sh[i];
        end
        @(negedge clk);
        start_i = 1'b0;
        check("b2b_last_err", 64'(err_o), 64'd1);
        @(negedge clk);

`ifdef ALU_MULT_EN
        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        check("mul_busy", 64'(busy_o), 64'd1);
        seen = 0;
        for (k = 1; k <= 40 && seen == 0; k++) begin
            if (valid_o) begin
                seen = k;
                check("mul_hi", 64'(hi_o), 64'hFFFF_FFFE);
                check("mul_lo", 64'(result_o), 64'h1);
                // Start in the DONE cycle must be ignored.
                start_i = 1'b1;
                alu_operation_i = 4'd3;
                a_i = 32'd2;
                b_i = 32'd2;
            end else begin
                start_i = (k >= 5 && k < 8);
                alu_operation_i = 4'd3;
                a_i = 32'd1;
                b_i = 32'd1;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        check("mul_latency", 64'(seen), 64'd33);
        check("mul_done_start_ignored", 64'(valid_o), 64'd0);
        check("mul_hold", 64'(result_o), 64'h1);
        check("mul_idle", 64'(busy_o), 64'd0);
        issue(4'b1000, 32'd7, 32'd9, 5'd0);
`else
        issue(4'b1000, 32'd6, 32'd7, 5'd0);
        check("mul_off_valid", 64'(valid_o), 64'd1);
        check("mul_off_err", 64'(err_o), 64'd1);
        check("mul_off_busy", 64'(busy_o), 64'd0);
        check("mul_off_res", 64'(result_o), 64'h0);
        issue(4'd3, 32'd10, 32'd20, 5'd0);
`endif
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_valid", 64'(valid_o), 64'd0);
        check("arst_result", 64'(result_o), 64'h0);
        check("arst_zero", 64'(zero_o), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_valid", 64'(valid_o), 64'd0);
        issue(4'd3, 32'd2, 32'd3, 5'd0);
        check("post_rst_add", 64'(result_o), 64'd5);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
